// File: rtl/lsu_mem_ctrl.sv
// LSU-to-memory sequencer: one request at a time, byte/half/word loads with extension,
// sub-word stores via read-modify-write, and a drain cycle after every write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new LSU request
// LOAD     | read port addressed, extended load data registered
// RMW_RD   | read port addressed, store bytes merged into old word
// WRITE    | one-cycle write pulse to the memory
// DRAIN    | memory commits the write; store response issued
// RESP     | load or error response issued
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_unsigned,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_w_enable,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [XLEN-1:0]   mem_w_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_DRAIN,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                err_q, err_d;
    logic [XLEN-1:0]     data_q, data_d;

    logic                misaligned;
    logic [XLEN-1:0]     load_ext;
    logic [XLEN-1:0]     store_merge;

    always_comb begin
        misaligned = (lsu_size == 2'b11)
                   || ((lsu_size == 2'b01) && lsu_addr[0])
                   || ((lsu_size == 2'b10) && (lsu_addr[1:0] != 2'b00));
    end

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = {{(XLEN-8){mem_rdata[7] & ~uns_q}}, mem_rdata[7:0]};
            2'b01:   load_ext = {{(XLEN-16){mem_rdata[15] & ~uns_q}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // data_q holds the right-aligned store data while in RMW_RD
    always_comb begin
        if (size_q == 2'b00) begin
            store_merge = {mem_rdata[XLEN-1:8], data_q[7:0]};
        end else begin
            store_merge = {mem_rdata[XLEN-1:16], data_q[15:0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        err_d        = err_q;
        data_d       = data_q;
        lsu_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        mem_r_addr   = '0;
        mem_w_enable = 1'b0;
        mem_w_addr   = '0;
        mem_w_data   = '0;

        case (state_q)
            ST_IDLE: begin
                lsu_ready = rst_n;
                if (lsu_valid) begin
                    addr_d = lsu_addr;
                    size_d = lsu_size;
                    uns_d  = lsu_unsigned;
                    err_d  = misaligned;
                    data_d = lsu_wdata;
                    if (misaligned) begin
                        state_d = ST_RESP;
                    end else if (!lsu_we) begin
                        state_d = ST_LOAD;
                    end else if (lsu_size == 2'b10) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_r_addr = addr_q;
                data_d     = load_ext;
                state_d    = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_r_addr = addr_q;
                data_d     = store_merge;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                mem_w_enable = 1'b1;
                mem_w_addr   = addr_q;
                mem_w_data   = data_q;
                state_d      = ST_DRAIN;
            end
            ST_DRAIN: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = err_q ? '0 : data_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-addressed memory model on the ports, plus a byte-level
// reference memory that predicts load results, write data and latencies.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_rdata;
    logic        mem_w_enable;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_r_addr   (mem_r_addr),
        .mem_rdata    (mem_rdata),
        .mem_w_enable (mem_w_enable),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data)
    );

    // Memory on the DUT ports: 4 KiB byte array, aliased on addr[11:0].
    logic [7:0]  mem_b [0:4095] = '{default: 8'h00};
    logic [7:0]  ref_b [0:4095] = '{default: 8'h00};
    logic [11:0] ra;
    logic        wr_pend = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    assign ra        = mem_r_addr[11:0];
    assign mem_rdata = {mem_b[ra + 12'd3], mem_b[ra + 12'd2], mem_b[ra + 12'd1], mem_b[ra]};

    always @(posedge clk) begin
        wr_pend <= mem_w_enable;
        wr_addr <= mem_w_addr;
        wr_data <= mem_w_data;
    end

    always @(negedge clk) begin
        if (wr_pend) begin
            for (int i = 0; i < 4; i++) begin
                mem_b[wr_addr[11:0] + 12'(i)] = wr_data[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [11:0] i;
        i = a[11:0];
        return {mem_b[i + 12'd3], mem_b[i + 12'd2], mem_b[i + 12'd1], mem_b[i]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [11:0] i;
        i = a[11:0];
        return {ref_b[i + 12'd3], ref_b[i + 12'd2], ref_b[i + 12'd1], ref_b[i]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] v;
        v = ref_word(a);
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ref_b[a[11:0] + 12'(i)] = d[8*i +: 8];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input bit hold,
                          output logic [31:0] rd_o, output logic [31:0] wd_o);
        logic        mis;
        int          exp_lat, lat, wen_cnt, wen_k, rdy_hi;
        logic [31:0] exp_rd, exp_wd, got_rd, got_wd, got_wa;
        logic        got_err;

        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp_rd = '0;
        exp_wd = '0;
        if (mis) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            exp_rd  = ref_load(a, sz, u);
        end else begin
            exp_lat = (sz == 2'b10) ? 2 : 3;
            ref_store(a, sz, d);
            exp_wd  = ref_word(a);
        end

        @(negedge clk);
        chk("ready_idle", {31'd0, lsu_ready}, 32'd1);
        chk("idle_quiet", {29'd0, rsp_valid, mem_w_enable, |mem_r_addr}, 32'd0);
        lsu_we       = we;
        lsu_size     = sz;
        lsu_unsigned = u;
        lsu_addr     = a;
        lsu_wdata    = d;
        lsu_valid    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) lsu_valid = 1'b0;

        lat = 0; wen_cnt = 0; wen_k = 0; rdy_hi = 0;
        got_rd = '0; got_wd = '0; got_wa = '0; got_err = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (lsu_ready) rdy_hi++;
            if (mem_w_enable) begin
                wen_cnt++;
                wen_k  = k;
                got_wd = mem_w_data;
                got_wa = mem_w_addr;
            end
            if (rsp_valid) begin
                lat     = k;
                got_rd  = rsp_rdata;
                got_err = rsp_err;
            end
        end
        lsu_valid = 1'b0;
        #1;

        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'd0, got_err}, {31'd0, mis});
        chk("rsp_rdata", got_rd, exp_rd);
        chk("ready_busy", rdy_hi, 0);
        chk("wen_count", wen_cnt, (we && !mis) ? 1 : 0);
        if (we && !mis) begin
            chk("wen_cycle", wen_k, exp_lat - 1);
            chk("w_data", got_wd, exp_wd);
            chk("w_addr", got_wa, a);
        end
        chk("mem_word", mem_word(a), ref_word(a));
        rd_o = got_rd;
        wd_o = got_wd;
    endtask

    logic [31:0] rd, wd;

    initial begin
        rst_n        = 1'b0;
        lsu_valid    = 1'b1;
        lsu_we       = 1'b1;
        lsu_size     = 2'b10;
        lsu_unsigned = 1'b0;
        lsu_addr     = 32'h100;
        lsu_wdata    = 32'h1234_5678;

        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, lsu_ready}, 32'd0);
            chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
            chk("rst_rdata", rsp_rdata, 32'd0);
            chk("rst_wen", {31'd0, mem_w_enable}, 32'd0);
            chk("rst_waddr", mem_w_addr, 32'd0);
            chk("rst_wdata", mem_w_data, 32'd0);
            chk("rst_raddr", mem_r_addr, 32'd0);
        end
        rst_n     = 1'b1;
        lsu_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", {31'd0, lsu_ready}, 32'd1);
            chk("post_rst_quiet", {30'd0, rsp_valid, mem_w_enable}, 32'd0);
        end

        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, rd, wd);
        chk("sw_wdata", wd, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, rd, wd);
        chk("lw_after_sw", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h1122_3344, 1'b0, rd, wd);
        do_req(1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_00AA, 1'b0, rd, wd);
        chk("sb_merge", wd, 32'h1122_33AA);
        do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 1'b0, rd, wd);
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, rd, wd);
        chk("sh_result", rd, 32'hBEEF_33AA);

        do_req(1'b1, 2'b10, 1'b0, 32'h300, 32'h0000_F080, 1'b0, rd, wd);
        do_req(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 1'b0, rd, wd);
        chk("lb", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h300, 32'h0, 1'b0, rd, wd);
        chk("lbu", rd, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b0, 32'h300, 32'h0, 1'b0, rd, wd);
        chk("lh", rd, 32'hFFFF_F080);
        do_req(1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 1'b0, rd, wd);
        chk("lhu", rd, 32'h0000_F080);

        do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, rd, wd);
        do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'hFFFF_FFFF, 1'b0, rd, wd);
        do_req(1'b1, 2'b11, 1'b0, 32'h100, 32'h5555_5555, 1'b0, rd, wd);
        do_req(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 1'b0, rd, wd);
        chk("mis_mem_kept", mem_word(32'h100), 32'hDEAD_BEEF);

        do_req(1'b1, 2'b00, 1'b0, 32'h204, 32'h0000_0077, 1'b1, rd, wd);
        do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b0, rd, wd);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, rd, wd);
        chk("wrap_lw", rd, 32'hCAFE_F00D);

        // Abort a sub-word store while it is reading the old word.
        do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h0BAD_F00D, 1'b0, rd, wd);
        @(negedge clk);
        lsu_we = 1'b1; lsu_size = 2'b00; lsu_addr = 32'h400; lsu_wdata = 32'h55;
        lsu_valid = 1'b1;
        @(posedge clk);
        #1 lsu_valid = 1'b0;
        @(negedge clk);
        chk("abort_rmw_raddr", mem_r_addr, 32'h400);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_quiet", {30'd0, rsp_valid, mem_w_enable}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_after", {30'd0, rsp_valid, mem_w_enable}, 32'd0);
        end
        chk("abort_mem", mem_word(32'h400), 32'h0BAD_F00D);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 1) == 0 ? 20'h0 : 20'($urandom()), 12'($urandom_range(0, 63))};
            do_req(1'($urandom()), 2'($urandom()), 1'($urandom()), a, $urandom(),
                   ($urandom_range(0, 7) == 0), rd, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
